// File: rtl/bt_pkg.sv
// Shared types and constants for the BT command scheduler: FSM states,
// requester indices and the command table (start index, byte length).
package bt_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP   = 3'd0,
    ST_W_INIT1 = 3'd1,
    ST_W_INIT2 = 3'd2,
    ST_IDLE    = 3'd3,
    ST_BUSY    = 3'd4
  } state_e;

  localparam logic [1:0] REQ_NEXT = 2'd0;
  localparam logic [1:0] REQ_PREV = 2'd1;
  localparam logic [1:0] REQ_VOLU = 2'd2;
  localparam logic [1:0] REQ_VOLD = 2'd3;

  localparam logic [4:0] INIT1_START = 5'd0;
  localparam logic [3:0] INIT1_LEN   = 4'd6;
  localparam logic [4:0] INIT2_START = 5'd6;
  localparam logic [3:0] INIT2_LEN   = 4'd10;
  localparam logic [4:0] NEXT_START  = 5'd16;
  localparam logic [3:0] NEXT_LEN    = 4'd4;
  localparam logic [4:0] PREV_START  = 5'd20;
  localparam logic [3:0] PREV_LEN    = 4'd4;
  localparam logic [4:0] VOLU_START  = 5'd24;
  localparam logic [3:0] VOLU_LEN    = 4'd4;
  localparam logic [4:0] VOLD_START  = 5'd28;
  localparam logic [3:0] VOLD_LEN    = 4'd4;

  typedef struct packed {
    logic [4:0] start;
    logic [3:0] len;
  } cmd_t;

  function automatic cmd_t req_cmd(input logic [1:0] idx);
    cmd_t c;
    c = '{start: VOLD_START, len: VOLD_LEN};
    case (idx)
      REQ_NEXT: c = '{start: NEXT_START, len: NEXT_LEN};
      REQ_PREV: c = '{start: PREV_START, len: PREV_LEN};
      REQ_VOLU: c = '{start: VOLU_START, len: VOLU_LEN};
      default:  c = '{start: VOLD_START, len: VOLD_LEN};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter: picks the first asserted request searching
// upward from ptr+1 (wrapping), ptr itself having lowest priority.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt
);

  logic [1:0] idx;

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    gnt = 4'b0000;
    idx = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) gnt = 4'b0001 << idx;
    end
  end

endmodule

// File: rtl/bt_cmd_sched.sv
// BT module command scheduler: power-up delay, two-step init handshake, then
// round-robin launch of user commands with a response timeout; outputs are registered.
module bt_cmd_sched
  import bt_pkg::*;
#(
  parameter int DLY_W = 17,
  parameter int TO_W  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       next_req,
  input  logic       prev_req,
  input  logic       volu_req,
  input  logic       vold_req,
  input  logic       resp_rcvd,
  output logic       send,
  output logic [4:0] cmd_start,
  output logic [3:0] cmd_len,
  output logic       cmd_n,
  output logic       ready,
  output logic       busy,
  output logic       err
);

  state_e           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [TO_W-1:0]  to_q, to_d, to_nxt;
  logic [3:0]       flag_q, flag_d, flag_clr, gnt, req_pulse;
  logic [1:0]       last_q, last_d, gnt_idx;
  logic             send_q, send_d, err_q, err_d;
  logic [4:0]       cmd_start_q, cmd_start_d;
  logic [3:0]       cmd_len_q, cmd_len_d;
  logic             waiting, dly_hit, to_hit;
  cmd_t             gnt_cmd;

  assign req_pulse = {vold_req, volu_req, prev_req, next_req};
  assign waiting   = (state_q == ST_W_INIT1) || (state_q == ST_W_INIT2) || (state_q == ST_BUSY);

  rr_arb4 u_arb (
    .req (flag_q),
    .ptr (last_q),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) gnt_idx = 2'(i);
    end
  end

  assign gnt_cmd = req_cmd(gnt_idx);

  always_comb begin
    dly_d = dly_q;
    if (state_q == ST_PWRUP && !(&dly_q)) dly_d = dly_q + DLY_W'(1);
    to_nxt = to_q;
    if (waiting && !(&to_q)) to_nxt = to_q + TO_W'(1);
  end

  // A response arriving in the same cycle as the timeout takes precedence.
  assign dly_hit = (state_q == ST_PWRUP) && (&dly_d);
  assign to_hit  = waiting && (&to_nxt) && !resp_rcvd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PWRUP;
      dly_q       <= '0;
      to_q        <= '0;
      flag_q      <= 4'b0000;
      last_q      <= 2'd3;
      send_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_start_q <= 5'd0;
      cmd_len_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      to_q        <= to_d;
      flag_q      <= flag_d;
      last_q      <= last_d;
      send_q      <= send_d;
      err_q       <= err_d;
      cmd_start_q <= cmd_start_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PWRUP:   if (dly_hit) state_d = ST_W_INIT1;
      ST_W_INIT1: if (resp_rcvd) state_d = ST_W_INIT2;
      ST_W_INIT2: if (resp_rcvd) state_d = ST_IDLE;
      ST_IDLE:    if (|flag_q) state_d = ST_BUSY;
      ST_BUSY:    if (resp_rcvd || to_hit) state_d = ST_IDLE;
      default:    state_d = ST_PWRUP;
    endcase
  end

  // Launch decisions; an INIT timeout re-sends the same entry.
  always_comb begin
    send_d      = 1'b0;
    err_d       = 1'b0;
    cmd_start_d = cmd_start_q;
    cmd_len_d   = cmd_len_q;
    flag_clr    = 4'b0000;
    last_d      = last_q;
    case (state_q)
      ST_PWRUP: begin
        if (dly_hit) begin
          send_d      = 1'b1;
          cmd_start_d = INIT1_START;
          cmd_len_d   = INIT1_LEN;
        end
      end
      ST_W_INIT1: begin
        if (resp_rcvd) begin
          send_d      = 1'b1;
          cmd_start_d = INIT2_START;
          cmd_len_d   = INIT2_LEN;
        end else if (to_hit) begin
          err_d       = 1'b1;
          send_d      = 1'b1;
          cmd_start_d = INIT1_START;
          cmd_len_d   = INIT1_LEN;
        end
      end
      ST_W_INIT2: begin
        if (to_hit) begin
          err_d       = 1'b1;
          send_d      = 1'b1;
          cmd_start_d = INIT2_START;
          cmd_len_d   = INIT2_LEN;
        end
      end
      ST_IDLE: begin
        if (|flag_q) begin
          send_d      = 1'b1;
          cmd_start_d = gnt_cmd.start;
          cmd_len_d   = gnt_cmd.len;
          flag_clr    = gnt;
          last_d      = gnt_idx;
        end
      end
      ST_BUSY: err_d = to_hit;
      default: ;
    endcase
    to_d   = send_d ? '0 : to_nxt;
    flag_d = (flag_q & ~flag_clr) | req_pulse;
  end

  always_comb begin
    busy  = waiting;
    ready = (state_q == ST_IDLE) || (state_q == ST_BUSY);
  end

  assign send      = send_q;
  assign err       = err_q;
  assign cmd_start = cmd_start_q;
  assign cmd_len   = cmd_len_q;
  assign cmd_n     = ~(&dly_q);

endmodule

// File: tb/tb_bt_cmd_sched.sv
// Bench for bt_cmd_sched with short delay/timeout widths: vector table, hand
// sequences for power-up, timeout and async reset, then random traffic vs a model.
module tb_bt_cmd_sched;

  localparam int DLY_W   = 4;
  localparam int TO_W    = 4;
  localparam int DLY_MAX = (1 << DLY_W) - 1;
  localparam int TO_MAX  = (1 << TO_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       next_req = 1'b0, prev_req = 1'b0, volu_req = 1'b0, vold_req = 1'b0;
  logic       resp_rcvd = 1'b0;
  logic       send, cmd_n, ready, busy, err;
  logic [4:0] cmd_start;
  logic [3:0] cmd_len;

  bt_cmd_sched #(.DLY_W(DLY_W), .TO_W(TO_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .next_req  (next_req),
    .prev_req  (prev_req),
    .volu_req  (volu_req),
    .vold_req  (vold_req),
    .resp_rcvd (resp_rcvd),
    .send      (send),
    .cmd_start (cmd_start),
    .cmd_len   (cmd_len),
    .cmd_n     (cmd_n),
    .ready     (ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and hold for a full cycle.
  task automatic drive(input logic [3:0] rq, input logic rsp);
    {vold_req, volu_req, prev_req, next_req} = rq;
    resp_rcvd = rsp;
    @(posedge clk);
    #1;
    {vold_req, volu_req, prev_req, next_req} = 4'b0000;
    resp_rcvd = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int s, input int st, input int ln,
                            input int cn, input int rd, input int bs, input int er);
    chk({tag, " send"}, send, s);
    chk({tag, " cmd_start"}, cmd_start, st);
    chk({tag, " cmd_len"}, cmd_len, ln);
    chk({tag, " cmd_n"}, cmd_n, cn);
    chk({tag, " ready"}, ready, rd);
    chk({tag, " busy"}, busy, bs);
    chk({tag, " err"}, err, er);
  endtask

  // Entered just after rst_n is released; ends in the INIT1 send cycle.
  task automatic pwrup_seq(input string tag);
    chk({tag, " cmd_n@0"}, cmd_n, 1);
    for (int i = 1; i < DLY_MAX; i++) begin
      drive(4'b0000, 1'b0);
      chk($sformatf("%s cmd_n@%0d", tag, i), cmd_n, 1);
      chk($sformatf("%s send@%0d", tag, i), send, 0);
    end
    drive(4'b0000, 1'b0);
    check_outs({tag, " init1"}, 1, 0, 6, 0, 0, 1, 0);
  endtask

  // Reference model: counts cycles since power-up and since the last launch,
  // tracks the outstanding command id (0/1 = INIT1/INIT2, 2..5 = requesters).
  int tab_start[6] = '{0, 6, 16, 20, 24, 28};
  int tab_len[6]   = '{6, 10, 4, 4, 4, 4};
  bit       m_powered, m_init_done, m_send, m_err;
  int       m_pwr, m_out, m_wait, m_last, m_start, m_len;
  bit [3:0] m_pend;

  task automatic m_launch(input int id);
    m_send  = 1;
    m_start = tab_start[id];
    m_len   = tab_len[id];
    m_out   = id;
    m_wait  = 0;
  endtask

  task automatic m_reset();
    m_powered = 0; m_init_done = 0; m_send = 0; m_err = 0;
    m_pwr = 0; m_out = -1; m_wait = 0; m_last = 3; m_start = 0; m_len = 0; m_pend = 4'b0000;
  endtask

  task automatic m_step(input bit [3:0] rq, input bit rsp);
    int idx;
    idx = 0;
    m_send = 0;
    m_err  = 0;
    if (!m_powered) begin
      m_pwr++;
      if (m_pwr == DLY_MAX) begin
        m_powered = 1;
        m_launch(0);
      end
    end else if (m_out >= 0) begin
      if (rsp) begin
        if (m_out == 0) m_launch(1);
        else begin
          if (m_out == 1) m_init_done = 1;
          m_out = -1;
        end
      end else begin
        m_wait++;
        if (m_wait == TO_MAX) begin
          m_err = 1;
          if (m_out < 2) m_launch(m_out);
          else m_out = -1;
        end
      end
    end else if (m_init_done && m_pend != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (m_pend[idx]) break;
      end
      m_pend[idx] = 0;
      m_last = idx;
      m_launch(idx + 2);
    end
    m_pend |= rq;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step({vold_req, volu_req, prev_req, next_req}, resp_rcvd);
  end

  task automatic cmp_model(input string tag);
    chk({tag, " send"}, send, m_send);
    chk({tag, " cmd_start"}, cmd_start, m_start);
    chk({tag, " cmd_len"}, cmd_len, m_len);
    chk({tag, " cmd_n"}, cmd_n, m_powered ? 0 : 1);
    chk({tag, " ready"}, ready, m_init_done);
    chk({tag, " busy"}, busy, (m_out >= 0) ? 1 : 0);
    chk({tag, " err"}, err, m_err);
  endtask

  typedef struct {
    logic [3:0] rq;
    logic       rsp;
    logic       e_send;
    int         e_start;
    int         e_len;
    logic       e_ready;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t vec[21];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rq;
    logic       rsp;
    bit         quiet;

    // Starting in the INIT1 send cycle; each row: inputs, outputs after the edge.
    vec[0]  = '{4'b0000, 1'b0, 1'b0, 0,  6,  1'b0, 1'b1, 1'b0};
    vec[1]  = '{4'b0000, 1'b1, 1'b1, 6,  10, 1'b0, 1'b1, 1'b0};
    vec[2]  = '{4'b1001, 1'b0, 1'b0, 6,  10, 1'b0, 1'b1, 1'b0};
    vec[3]  = '{4'b0000, 1'b1, 1'b0, 6,  10, 1'b1, 1'b0, 1'b0};
    vec[4]  = '{4'b0000, 1'b0, 1'b1, 16, 4,  1'b1, 1'b1, 1'b0};
    vec[5]  = '{4'b0000, 1'b0, 1'b0, 16, 4,  1'b1, 1'b1, 1'b0};
    vec[6]  = '{4'b0000, 1'b1, 1'b0, 16, 4,  1'b1, 1'b0, 1'b0};
    vec[7]  = '{4'b0000, 1'b0, 1'b1, 28, 4,  1'b1, 1'b1, 1'b0};
    vec[8]  = '{4'b0010, 1'b0, 1'b0, 28, 4,  1'b1, 1'b1, 1'b0};
    vec[9]  = '{4'b0010, 1'b0, 1'b0, 28, 4,  1'b1, 1'b1, 1'b0};
    vec[10] = '{4'b0010, 1'b1, 1'b0, 28, 4,  1'b1, 1'b0, 1'b0};
    vec[11] = '{4'b0000, 1'b0, 1'b1, 20, 4,  1'b1, 1'b1, 1'b0};
    vec[12] = '{4'b0000, 1'b1, 1'b0, 20, 4,  1'b1, 1'b0, 1'b0};
    vec[13] = '{4'b0000, 1'b0, 1'b0, 20, 4,  1'b1, 1'b0, 1'b0};
    vec[14] = '{4'b0100, 1'b0, 1'b0, 20, 4,  1'b1, 1'b0, 1'b0};
    vec[15] = '{4'b0100, 1'b0, 1'b1, 24, 4,  1'b1, 1'b1, 1'b0};
    vec[16] = '{4'b0000, 1'b1, 1'b0, 24, 4,  1'b1, 1'b0, 1'b0};
    vec[17] = '{4'b0000, 1'b0, 1'b1, 24, 4,  1'b1, 1'b1, 1'b0};
    vec[18] = '{4'b0000, 1'b1, 1'b0, 24, 4,  1'b1, 1'b0, 1'b0};
    vec[19] = '{4'b0000, 1'b1, 1'b0, 24, 4,  1'b1, 1'b0, 1'b0};
    vec[20] = '{4'b0000, 1'b0, 1'b0, 24, 4,  1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 1, 0, 0, 0);
    rst_n = 1'b1;
    pwrup_seq("pwrup");

    for (int i = 0; i < 21; i++) begin
      drive(vec[i].rq, vec[i].rsp);
      check_outs($sformatf("vec%0d", i), vec[i].e_send, vec[i].e_start, vec[i].e_len,
                 0, vec[i].e_ready, vec[i].e_busy, vec[i].e_err);
    end

    // BUSY timeout: command dropped, no relaunch afterwards.
    drive(4'b0001, 1'b0);
    chk("to pend send", send, 0);
    drive(4'b0000, 1'b0);
    check_outs("to launch", 1, 16, 4, 0, 1, 1, 0);
    for (int i = 1; i < TO_MAX; i++) begin
      drive(4'b0000, 1'b0);
      chk($sformatf("to wait%0d err", i), err, 0);
      chk($sformatf("to wait%0d busy", i), busy, 1);
    end
    drive(4'b0000, 1'b0);
    check_outs("to expire", 0, 16, 4, 0, 1, 0, 1);
    drive(4'b0000, 1'b0);
    check_outs("to after", 0, 16, 4, 0, 1, 0, 0);
    drive(4'b0000, 1'b0);
    chk("to no relaunch", send, 0);

    // Asynchronous reset in the middle of BUSY.
    drive(4'b0100, 1'b0);
    drive(4'b0000, 1'b0);
    check_outs("mid launch", 1, 24, 4, 0, 1, 1, 0);
    drive(4'b0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check_outs("rst_hold", 0, 0, 0, 1, 0, 0, 0);
    rst_n = 1'b1;
    pwrup_seq("repwr");

    // INIT1 timeout resends INIT1, then init completes normally.
    for (int i = 1; i < TO_MAX; i++) begin
      drive(4'b0000, 1'b0);
      chk($sformatf("i1to wait%0d err", i), err, 0);
      chk($sformatf("i1to wait%0d send", i), send, 0);
    end
    drive(4'b0000, 1'b0);
    check_outs("i1to resend", 1, 0, 6, 0, 0, 1, 1);
    drive(4'b0000, 1'b1);
    check_outs("i1to init2", 1, 6, 10, 0, 0, 1, 0);
    drive(4'b0000, 1'b1);
    check_outs("i1to ready", 0, 6, 10, 0, 1, 0, 0);
    drive(4'b0000, 1'b0);
    check_outs("i1to idle", 0, 6, 10, 0, 1, 0, 0);

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    drive(4'b0000, 1'b0);
    cmp_model("rnd reset");
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        cmp_model("rnd midrst");
        rst_n = 1'b1;
      end
      quiet = ((c / 300) % 2) == 0;
      rq = 4'b0000;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) rq[b] = 1'b1;
      end
      rsp = ($urandom_range(0, quiet ? 40 : 3) == 0);
      drive(rq, rsp);
      cmp_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bt_cmd_sched.md
BT_CMD_SCHED -- requirements
Module: bt_cmd_sched

Interface
REQ-001 Parameter DLY_W, default 17: power-up delay counter width; the delay is 2^DLY_W-1 cycles.
REQ-002 Parameter TO_W, default 20: response timeout counter width; the timeout is 2^TO_W-1 cycles.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 next_req, prev_req, volu_req, vold_req  input  1 each  single-cycle request pulses (requesters 0..3).
REQ-006 resp_rcvd  input  1  command-complete pulse from snd_cmd.
REQ-007 send  output  1  single-cycle command launch to snd_cmd.
REQ-008 cmd_start  output  5  command table start index.
REQ-009 cmd_len  output  4  command length in bytes.
REQ-010 cmd_n  output  1  BT module command-mode pin; high during power-up delay, low afterward.
REQ-011 ready  output  1  high once the init sequence has completed.
REQ-012 busy  output  1  high while a command is outstanding.
REQ-013 err  output  1  single-cycle pulse on response timeout.

Function
REQ-014 Command table (start,len) SHALL be: INIT1 (0,6), INIT2 (6,10), NEXT (16,4), PREV (20,4), VOLU (24,4), VOLD (28,4).
REQ-015 States SHALL be PWRUP, W_INIT1, W_INIT2, IDLE, BUSY.
REQ-016 PWRUP: delay counter increments and saturates at all-ones; on saturation, pulse send with INIT1, go to W_INIT1.
REQ-017 cmd_n SHALL equal the inverse of the AND-reduction of the delay counter.
REQ-018 W_INIT1 + resp_rcvd: pulse send with INIT2, go to W_INIT2; W_INIT2 + resp_rcvd: set ready, go to IDLE.
REQ-019 Each requester SHALL have a pending flag, set by its request pulse and cleared on grant; repeated pulses while pending merge into one.
REQ-020 Requests arriving before ready SHALL be latched and served after init.
REQ-021 IDLE with any flag pending: grant round-robin starting at index (last_grant+1) mod 4; pulse send with that entry; clear its flag; go to BUSY; last_grant resets to 3.
REQ-022 A request pulse in the same cycle its flag is cleared SHALL leave the flag set (set wins).
REQ-023 BUSY + resp_rcvd: go to IDLE; the next grant occurs no earlier than the following cycle.
REQ-024 cmd_start/cmd_len SHALL be registered, valid in the send cycle, and held until the next send.
REQ-025 send SHALL be high exactly one cycle per command; send latency is 1 cycle from IDLE with a flag pending.
REQ-026 The timeout counter SHALL clear on every send and count while in W_INIT1, W_INIT2, or BUSY.
REQ-027 On timeout saturation: pulse err for one cycle; in BUSY, drop the command and go to IDLE; in W_INITx, resend the same INIT entry.
REQ-028 resp_rcvd in PWRUP or IDLE SHALL be ignored.
REQ-029 busy SHALL be high in W_INIT1, W_INIT2, and BUSY.

Reset
REQ-030 Asserting rst_n low, at any time including mid-command, SHALL force: state PWRUP, counters 0, flags 0, send 0, cmd_start 0, cmd_len 0, cmd_n 1, ready 0, busy 0, err 0.

Structure
REQ-031 Package bt_pkg SHALL hold the state enum, the requester index constants, and the command-table start/length constants.
REQ-032 The round-robin grant logic SHALL be one sub-module, rr_arb4 (4 requests, pointer in, one-hot grant out).

Verification
REQ-033 Reset with DLY_W=4: cmd_n stays 1 for 15 cycles, then 0, with send and INIT1 (0,6) in the same cycle.
REQ-034 Two resp_rcvd pulses after INIT1: INIT2 (6,10) is sent, then ready rises.
REQ-035 next_req and vold_req in the same cycle while IDLE: NEXT (16,4) is sent first, then VOLD (28,4) after resp_rcvd.
REQ-036 prev_req pulsed 3 times while BUSY: exactly one PREV (20,4) send follows.
REQ-037 TO_W=4 with no resp_rcvd in BUSY: err pulses after 15 cycles, state returns to IDLE, and the pending flag stays cleared.
REQ-038 rst_n low in the middle of BUSY: all outputs take reset values asynchronously, and the init sequence restarts.
